// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, fetch and data-memory
// requests into per-stage write enables and flushes, with DMEM timeout and perf counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_use_hazard,
  input  logic             branch_taken_ex,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic            r_dmem_timeout, w_timeout_nxt;
  logic            w_freeze;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_dmem_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_dmem_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic; a release cycle in DMEM_WAIT falls through to the RUN priorities
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_dmem_timeout;
    w_freeze       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          w_freeze       = 1'b1;
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = WC_ONE;
        end else begin
          w_freeze = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!dmem_ready) begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WC_LAST) begin
            w_state_nxt   = ST_ERROR;
            w_timeout_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WC_ONE;
          end
        end else begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        // Unreachable encoding: lock up safely and report it
        w_freeze      = 1'b1;
        w_state_nxt   = ST_ERROR;
        w_timeout_nxt = 1'b1;
      end
    endcase
  end

  // Per-stage controls; branch beats load-use because the dependent instruction is squashed
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if (w_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (branch_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use_hazard || !imem_ready) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write && (r_stall_cycles != CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (if_id_flush && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign dmem_timeout = r_dmem_timeout;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push expected outputs,
// a negedge monitor pops and compares. Small counters and timeout exercise the boundaries.
module tb_pipeline_stall_controller;

  localparam int TO = 4;
  localparam int CW = 4;

  // control vector order: pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write
  localparam logic [5:0] NORM = 6'b110011;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BR   = 6'b111111;
  localparam logic [5:0] LU   = 6'b000111;

  typedef struct {
    logic [5:0]    ctl;
    logic          tm;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    int            id;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, load_use_hazard, branch_taken_ex, imem_ready, dmem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write, dmem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .load_use_hazard(load_use_hazard), .branch_taken_ex(branch_taken_ex),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .dmem_timeout(dmem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic lu, input logic br, input logic imr,
                      input logic req, input logic rdy, input logic [5:0] ctl,
                      input logic tm, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #2;
    rstn = rn; load_use_hazard = lu; branch_taken_ex = br;
    imem_ready = imr; dmem_req = req; dmem_ready = rdy;
    e.ctl = ctl; e.tm = tm; e.sc = CW'(sc); e.fc = CW'(fc); e.id = vec_id;
    vec_id++;
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle after the driver has settled
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};
      checks += 4;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl vec %0d: got %b expected %b", e.id, got, e.ctl);
      end
      if (dmem_timeout !== e.tm) begin
        errors++;
        $display("FAIL dmem_timeout vec %0d: got %b expected %b", e.id, dmem_timeout, e.tm);
      end
      if (stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles vec %0d: got %0d expected %0d", e.id, stall_cycles, e.sc);
      end
      if (flush_count !== e.fc) begin
        errors++;
        $display("FAIL flush_count vec %0d: got %0d expected %0d", e.id, flush_count, e.fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; load_use_hazard = 1'b0; branch_taken_ex = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    //    rn    lu    br    imr   req   rdy   ctl   tm    sc  fc
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LU,   1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BR,   1'b0, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, 1, 1);
    // three-cycle memory wait, released on the fourth
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 2, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 3, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 4, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NORM, 1'b0, 5, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 5, 1);
    // branch held through a wait: flush only in the release cycle
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 5, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 6, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BR,   1'b0, 7, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 7, 2);
    // memory ready in the request cycle: no freeze, load-use applies
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, LU,   1'b0, 7, 2);
    // timeout: four frozen cycles then ERROR, which ignores ready and branch
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ,  1'b0, 8, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b0, 9, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b0, 10, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b0, 11, 2);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FRZ,  1'b1, 12, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FRZ,  1'b1, 13, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b1, 14, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b1, 15, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b1, 15, 2);
    // reset pulse clears the error and counters, RUN rules apply during reset
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BR,   1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
